// File: rtl/gl_cmd_fetch.sv
// gl_cmd_fetch: command-stream fetch unit for the GL pipeline.
// Reads header and operand words from a 1-cycle-latency instruction BRAM
// and hands them to decode on two valid/ready channels (header, operand).
//
// state  | meaning
// S_REQ  | issue BRAM read at pc
// S_WAIT | BRAM data returns; latch into header or operand output register
// S_OUT  | present the latched word; hold until the consumer takes it
// S_DONE | END opcode fetched; fetch halted until redirect or reset
module gl_cmd_fetch #(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter logic [ADDR_W-1:0]  TEXT_START = '0,
    parameter int                 OPD_W      = 5
) (
    input  logic              clk,
    input  logic              reset,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [DATA_W-1:0] cmd_header,
    output logic [7:0]        cmd_opcode,
    output logic [OPD_W-1:0]  cmd_nopd,
    output logic [ADDR_W-1:0] cmd_addr,

    output logic              opd_valid,
    input  logic              opd_ready,
    output logic [DATA_W-1:0] opd_data,
    output logic [OPD_W-1:0]  opd_idx,
    output logic              opd_last,

    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,

    output logic              done,
    output logic              unknown_op
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(DATA_W / 8);
    localparam logic [7:0]        OP_END  = 8'hFF;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic {
        PH_HDR = 1'b0,
        PH_OPD = 1'b1
    } phase_t;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [OPD_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   cmd_header_q, cmd_header_d;
    logic [OPD_W-1:0]    cmd_nopd_q, cmd_nopd_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   opd_data_q, opd_data_d;
    logic [OPD_W-1:0]    opd_idx_q, opd_idx_d;
    logic                opd_last_q, opd_last_d;
    logic                done_q, done_d;
    logic                unknown_q, unknown_d;
    logic                handshake;

    function automatic logic [OPD_W-1:0] nopd_of(input logic [7:0] op);
        case (op)
            8'h03, 8'h04:                      nopd_of = OPD_W'(3);
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18: nopd_of = OPD_W'(16);
            8'h19:                             nopd_of = OPD_W'(4);
            8'h1A:                             nopd_of = OPD_W'(6);
            default:                           nopd_of = '0;
        endcase
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        case (op)
            8'h00, 8'h03, 8'h04, 8'h11, 8'h13,
            8'h16, 8'h17, 8'h18, 8'h19, 8'h1A: op_known = 1'b1;
            default:                           op_known = 1'b0;
        endcase
    endfunction

    // The read strobe is masked while reset is held so no read leaves the
    // block during reset even though the reset state is S_REQ.
    assign mem_rd_en  = reset && (state_q == S_REQ);
    assign mem_addr   = pc_q;
    assign cmd_valid  = (state_q == S_OUT) && (phase_q == PH_HDR);
    assign opd_valid  = (state_q == S_OUT) && (phase_q == PH_OPD);
    assign cmd_header = cmd_header_q;
    assign cmd_opcode = cmd_header_q[7:0];
    assign cmd_nopd   = cmd_nopd_q;
    assign cmd_addr   = cmd_addr_q;
    assign opd_data   = opd_data_q;
    assign opd_idx    = opd_idx_q;
    assign opd_last   = opd_last_q;
    assign done       = done_q;
    assign unknown_op = unknown_q;

    assign handshake = (state_q == S_OUT) &&
                       ((phase_q == PH_HDR) ? cmd_ready : opd_ready);

    // Next-state logic: redirect overrides the sequencer; a handshake that
    // coincides with a redirect is still consumed by decode.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        pc_d         = pc_q;
        idx_d        = idx_q;
        cmd_header_d = cmd_header_q;
        cmd_nopd_d   = cmd_nopd_q;
        cmd_addr_d   = cmd_addr_q;
        opd_data_d   = opd_data_q;
        opd_idx_d    = opd_idx_q;
        opd_last_d   = opd_last_q;
        done_d       = done_q;
        unknown_d    = unknown_q;

        if (redirect_valid) begin
            pc_d    = redirect_addr;
            state_d = S_REQ;
            phase_d = PH_HDR;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_REQ: state_d = S_WAIT;
                S_WAIT: begin
                    if (phase_q == PH_HDR) begin
                        if (mem_rdata[7:0] == OP_END) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            cmd_header_d = mem_rdata;
                            cmd_nopd_d   = nopd_of(mem_rdata[7:0]);
                            cmd_addr_d   = pc_q;
                            if (!op_known(mem_rdata[7:0])) begin
                                unknown_d = 1'b1;
                            end
                            state_d = S_OUT;
                        end
                    end else begin
                        opd_data_d = mem_rdata;
                        opd_idx_d  = idx_q;
                        opd_last_d = (idx_q == cmd_nopd_q - OPD_W'(1));
                        state_d    = S_OUT;
                    end
                end
                S_OUT: begin
                    if (handshake) begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = S_REQ;
                        if (phase_q == PH_HDR) begin
                            if (cmd_nopd_q != '0) begin
                                phase_d = PH_OPD;
                                idx_d   = '0;
                            end
                        end else begin
                            idx_d = idx_q + OPD_W'(1);
                            if (opd_last_q) begin
                                phase_d = PH_HDR;
                            end
                        end
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_REQ;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_REQ;
            phase_q      <= PH_HDR;
            pc_q         <= TEXT_START;
            idx_q        <= '0;
            cmd_header_q <= '0;
            cmd_nopd_q   <= '0;
            cmd_addr_q   <= '0;
            opd_data_q   <= '0;
            opd_idx_q    <= '0;
            opd_last_q   <= 1'b0;
            done_q       <= 1'b0;
            unknown_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            cmd_header_q <= cmd_header_d;
            cmd_nopd_q   <= cmd_nopd_d;
            cmd_addr_q   <= cmd_addr_d;
            opd_data_q   <= opd_data_d;
            opd_idx_q    <= opd_idx_d;
            opd_last_q   <= opd_last_d;
            done_q       <= done_d;
            unknown_q    <= unknown_d;
        end
    end

endmodule

// File: tb/tb_gl_cmd_fetch.sv
// Bench for gl_cmd_fetch: BRAM model, scoreboard of expected header/operand
// words checked on every handshake, opcode table loop, and hand-written
// sequences for timing, backpressure, redirect, reset and a 64-bit instance.
module tb_gl_cmd_fetch;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset = 1'b0;
    logic           cmd_ready, opd_ready, redirect_valid;
    logic [AW-1:0]  redirect_addr, mem_addr, cmd_addr;
    logic           mem_rd_en, cmd_valid, opd_valid, opd_last, done, unknown_op;
    logic [DW-1:0]  mem_rdata, cmd_header, opd_data;
    logic [7:0]     cmd_opcode;
    logic [OW-1:0]  cmd_nopd, opd_idx;

    gl_cmd_fetch #(.ADDR_W(AW), .DATA_W(DW), .TEXT_START(32'h0), .OPD_W(OW)) u_dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_header(cmd_header),
        .cmd_opcode(cmd_opcode), .cmd_nopd(cmd_nopd), .cmd_addr(cmd_addr),
        .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_data(opd_data),
        .opd_idx(opd_idx), .opd_last(opd_last),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .done(done), .unknown_op(unknown_op)
    );

    logic [DW-1:0] mem [0:511];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr[10:2]];

    // 64-bit instance: pc must step by 8
    logic           reset64 = 1'b0;
    logic [AW-1:0]  mem_addr64, cmd_addr64;
    logic           mem_rd_en64, cmd_valid64, opd_valid64, opd_last64, done64, unknown_op64;
    logic [63:0]    mem_rdata64, cmd_header64, opd_data64;
    logic [7:0]     cmd_opcode64;
    logic [OW-1:0]  cmd_nopd64, opd_idx64;

    gl_cmd_fetch #(.ADDR_W(AW), .DATA_W(64), .TEXT_START(32'h0), .OPD_W(OW)) u_dut64 (
        .clk(clk), .reset(reset64),
        .mem_addr(mem_addr64), .mem_rd_en(mem_rd_en64), .mem_rdata(mem_rdata64),
        .cmd_valid(cmd_valid64), .cmd_ready(1'b1), .cmd_header(cmd_header64),
        .cmd_opcode(cmd_opcode64), .cmd_nopd(cmd_nopd64), .cmd_addr(cmd_addr64),
        .opd_valid(opd_valid64), .opd_ready(1'b1), .opd_data(opd_data64),
        .opd_idx(opd_idx64), .opd_last(opd_last64),
        .redirect_valid(1'b0), .redirect_addr(32'h0),
        .done(done64), .unknown_op(unknown_op64)
    );

    logic [63:0] mem64 [0:15];
    always @(posedge clk) if (mem_rd_en64) mem_rdata64 <= mem64[mem_addr64[6:3]];

    logic [AW-1:0] rd64_q[$];
    always @(negedge clk) if (reset64 === 1'b1 && mem_rd_en64 === 1'b1) rd64_q.push_back(mem_addr64);

    // Scoreboard
    typedef struct {
        bit            hdr;
        logic [DW-1:0] data;
        logic [OW-1:0] n;
        logic [AW-1:0] addr;
        logic [OW-1:0] idx;
        bit            last;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] last_rd_addr = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops one expected word
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (mem_rd_en === 1'b1) last_rd_addr <= mem_addr;
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_extra_hdr: got header %0h at %0h expected none", cmd_header, cmd_addr);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_hdr", {1'b1, cmd_header, cmd_opcode, cmd_nopd, cmd_addr},
                        {mon_e.hdr, mon_e.data, mon_e.data[7:0], mon_e.n, mon_e.addr});
                end
            end
            if (opd_valid === 1'b1 && opd_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_extra_opd: got operand %0h idx %0d expected none", opd_data, opd_idx);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_opd", {1'b0, opd_data, opd_idx, opd_last},
                        {mon_e.hdr, mon_e.data, mon_e.idx, mon_e.last});
                end
            end
        end
    end

    task automatic begin_test();
        reset = 1'b0;
        cmd_ready = 1'b1; opd_ready = 1'b1;
        redirect_valid = 1'b0; redirect_addr = '0;
        for (int k = 0; k < 512; k++) mem[k] = 32'h0000_00FF;
        sb_q.delete();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Write a command into memory and queue what decode must see.
    task automatic put_cmd(input int wa, input logic [DW-1:0] hdr, input int n, input int n_push);
        exp_t e;
        mem[wa] = hdr;
        e.hdr = 1'b1; e.data = hdr; e.n = OW'(n); e.addr = AW'(wa * 4); e.idx = '0; e.last = 1'b0;
        sb_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            mem[wa + 1 + k] = 32'hD000_0000 | 32'(wa << 8) | 32'(k);
            if (k < n_push) begin
                e.hdr = 1'b0; e.data = mem[wa + 1 + k]; e.n = '0; e.addr = '0;
                e.idx = OW'(k); e.last = (k == n - 1);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic put_end(input int wa);
        mem[wa] = 32'h1234_56FF;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk({name, "_done"}, done, 1);
        @(negedge clk);
        chk({name, "_sb_empty"}, sb_q.size(), 0);
    endtask

    task automatic wait_hdr(input string name, input logic [AW-1:0] a, input int budget);
        int n = 0;
        while (!(cmd_valid === 1'b1 && cmd_addr === a) && n < budget) begin @(negedge clk); n++; end
        chk({name, "_reached"}, (cmd_valid === 1'b1 && cmd_addr === a), 1);
    endtask

    task automatic wait_opd(input string name, input int idx, input int budget);
        int n = 0;
        while (!(opd_valid === 1'b1 && opd_idx === OW'(idx)) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_reached"}, (opd_valid === 1'b1 && opd_idx === OW'(idx)), 1);
    endtask

    typedef struct {
        logic [7:0] op;
        int         n;
        bit         unk;
    } vec_t;

    vec_t vt [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit rd_seen;

        vt[0]  = '{8'h03, 3, 1'b0};  vt[1]  = '{8'h04, 3, 1'b0};
        vt[2]  = '{8'h11, 16, 1'b0}; vt[3]  = '{8'h13, 16, 1'b0};
        vt[4]  = '{8'h16, 16, 1'b0}; vt[5]  = '{8'h17, 16, 1'b0};
        vt[6]  = '{8'h18, 16, 1'b0}; vt[7]  = '{8'h19, 4, 1'b0};
        vt[8]  = '{8'h1A, 6, 1'b0};  vt[9]  = '{8'h00, 0, 1'b0};
        vt[10] = '{8'h42, 0, 1'b1};  vt[11] = '{8'hFE, 0, 1'b1};

        // Reset values and first-command timing
        begin_test();
        put_cmd(0, 32'hABCD_0003, 3, 3);
        put_end(4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {mem_rd_en, mem_addr, cmd_valid, opd_valid, done, unknown_op,
                            cmd_header, cmd_nopd, cmd_addr, opd_data, opd_idx, opd_last}, '0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("c0_rd", {mem_rd_en, mem_addr, cmd_valid}, {1'b1, 32'h0, 1'b0});
        @(negedge clk);
        chk("c1_wait", {mem_rd_en, cmd_valid}, 2'b00);
        @(negedge clk);
        chk("c2_hdr", {cmd_valid, cmd_opcode, cmd_nopd, cmd_addr, mem_rd_en},
            {1'b1, 8'h03, 5'd3, 32'h0, 1'b0});
        wait_done("t1", 100);
        rd_seen = 1'b0;
        repeat (6) begin @(negedge clk); if (mem_rd_en !== 1'b0) rd_seen = 1'b1; end
        chk("t1_no_rd_after_done", rd_seen, 0);
        chk("t1_unknown", unknown_op, 0);

        // Opcode table: operand counts, unknown flag, next header address
        for (int i = 0; i < 12; i++) begin
            begin_test();
            put_cmd(0, {16'h5A00, 8'(i), vt[i].op}, vt[i].n, vt[i].n);
            put_end(vt[i].n + 1);
            release_reset();
            wait_done($sformatf("tbl_%02h", vt[i].op), 300);
            chk($sformatf("tbl_%02h_unknown", vt[i].op), unknown_op, vt[i].unk);
            chk($sformatf("tbl_%02h_end_addr", vt[i].op), last_rd_addr, 32'((vt[i].n + 1) * 4));
        end

        // Unknown opcode at 0x20 is sticky across later commands
        begin_test();
        for (int k = 0; k < 8; k++) put_cmd(k, 32'h0000_0000, 0, 0);
        put_cmd(8, 32'h0000_0042, 0, 0);
        put_cmd(9, 32'h0000_0003, 3, 3);
        put_end(13);
        release_reset();
        wait_hdr("unk_1c", 32'h1C, 100);
        chk("unk_before", unknown_op, 0);
        wait_hdr("unk_20", 32'h20, 20);
        chk("unk_at_20", {unknown_op, cmd_nopd}, {1'b1, 5'd0});
        wait_hdr("unk_24", 32'h24, 20);
        wait_done("unk", 100);
        chk("unk_sticky", unknown_op, 1);

        // Operand backpressure at idx 1
        begin_test();
        put_cmd(0, 32'h0000_0003, 3, 3);
        put_end(4);
        release_reset();
        opd_ready = 1'b0;
        wait_opd("bp0", 0, 20);
        opd_ready = 1'b1;
        @(posedge clk); #1 opd_ready = 1'b0;
        wait_opd("bp1", 1, 20);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold", {opd_valid, opd_data, opd_idx, mem_rd_en},
                {1'b1, 32'hD000_0001, 5'd1, 1'b0});
        end
        opd_ready = 1'b1;
        wait_done("bp", 50);

        // Redirect to 0x100 in the same cycle as the idx 5 handshake
        begin_test();
        put_cmd(0, 32'h0000_0011, 16, 6);
        put_cmd(64, 32'h0000_0004, 3, 3);
        put_end(68);
        release_reset();
        wait_opd("rd5", 5, 60);
        redirect_valid = 1'b1; redirect_addr = 32'h100;
        @(posedge clk); #1 redirect_valid = 1'b0;
        chk("rd_next", {opd_valid, cmd_valid, mem_rd_en, mem_addr}, {1'b0, 1'b0, 1'b1, 32'h100});
        wait_done("rd", 100);

        // Redirect together with reset: reset wins
        begin_test();
        put_cmd(0, 32'h0000_0011, 16, 5);
        release_reset();
        wait_opd("rr5", 5, 60);
        redirect_valid = 1'b1; redirect_addr = 32'h100; reset = 1'b0;
        @(posedge clk); #1 redirect_valid = 1'b0;
        chk("rr_reset", {opd_valid, cmd_valid, mem_rd_en, mem_addr, opd_idx, done},
            {1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0});
        chk("rr_sb_empty", sb_q.size(), 0);

        // Redirect out of S_DONE
        begin_test();
        put_cmd(0, 32'h0000_0003, 3, 3);
        put_end(4);
        release_reset();
        wait_done("dr_first", 100);
        put_cmd(16, 32'h0000_0019, 4, 4);
        put_end(21);
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_addr = 32'h40;
        @(posedge clk); #1 redirect_valid = 1'b0;
        chk("dr_resume", {done, mem_rd_en, mem_addr}, {1'b0, 1'b1, 32'h40});
        wait_done("dr", 100);

        // 64-bit words: pc steps by 8
        for (int k = 0; k < 16; k++) mem64[k] = 64'hFF;
        mem64[0] = 64'h0000_0000_0000_0003;
        for (int k = 0; k < 3; k++) mem64[1 + k] = 64'hE000_0000_0000_0000 | 64'(k);
        mem64[4] = 64'hFF;
        @(posedge clk); #1 reset64 = 1'b1;
        for (int n = 0; n < 60 && done64 !== 1'b1; n++) @(negedge clk);
        chk("w64_done", done64, 1);
        chk("w64_nreads", rd64_q.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < rd64_q.size()) chk($sformatf("w64_addr%0d", k), rd64_q[k], 32'(k * 8));
        chk("w64_last_opd", {opd_data64, opd_idx64, opd_last64, cmd_addr64},
            {64'hE000_0000_0000_0002, 5'd2, 1'b1, 32'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
